hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard controller for the 3-stage RV32I core (Fetch/Decode -> Execute -> Mem/Writeback).
- Tracks destination registers of the two most recently retired-into-writeback instructions.
- Drives the Execute-stage operand forwarding selects, load-use stalls and control-transfer flushes.
- Keeps saturating stall and flush event counters for the CSR/perf block.

Parameters:
- LOAD_STALL, 1, 1 = load data is not available on the Data_D path in MW, so a dependent instruction stalls one cycle; 0 = forward loads directly.
- FLUSH_CYCLES, 1, number of cycles flush is asserted per redirect (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- x_valid  in  1  instruction in Execute is real (not a bubble)
- x_rs1  in  5  rs1 index of Execute instruction
- x_rs2  in  5  rs2 index of Execute instruction
- x_use_rs1  in  1  Execute instruction reads rs1
- x_use_rs2  in  1  Execute instruction reads rs2
- x_rd  in  5  rd index of Execute instruction
- x_regwen  in  1  Execute instruction writes rd
- x_is_load  in  1  Execute instruction is a load
- x_redirect  in  1  branch taken / JAL / JALR resolved in Execute this cycle
- data_asel  out  2  operand A select: 00 REG, 10 DATA_D, 11 DATA_D_ff1
- data_bsel  out  2  operand B select, same encoding
- stall  out  1  hold PC and Decode->Execute registers; inject bubble into MW
- flush  out  1  squash the instruction entering Execute (Decode register becomes bubble)
- stall_count  out  32  saturating count of stall cycles
- flush_count  out  32  saturating count of redirects accepted

Behaviour:
- History: two entries W (instruction now in MW, producing Data_D) and W1 (one cycle older, producing Data_D_ff1). Each entry holds {valid, rd, regwen, is_load}.
- History update every cycle:
  - W1 <= W.
  - W <= {x_valid & ~stall & ~in_flush, x_rd, x_regwen, x_is_load}; a stall or in_flush cycle pushes a bubble into W.
- Entry "hits" rsN when: valid & regwen & rd != 0 & rd == rsN & x_use_rsN & x_valid.
- Select (combinational, per operand): W hit -> 10; else W1 hit -> 11; else 00. W has priority over W1. 01 is never driven. rs = x0 always gives 00.
- Load-use stall (LOAD_STALL=1): stall = x_valid & (W hit on rs1 or rs2) & W.is_load.
  - During the stall cycle the selects are don't-care but are driven to 00.
  - Next cycle the load sits in W1, the stall condition clears, and the operand selects 11.
  - Stall is never asserted for 2 consecutive cycles for the same instruction.
- LOAD_STALL=0: stall tied to 0.
- Redirect is accepted only when x_redirect & x_valid & ~stall & ~in_flush. Stall has priority; a redirect seen while stalled is ignored because upstream re-presents it the next cycle.
- Flush control, states RUN and FLUSH:
  - RUN: flush = accepted redirect (combinational, same cycle). If FLUSH_CYCLES > 1, load flush_cnt = FLUSH_CYCLES-1 and go to FLUSH.
  - FLUSH: flush = 1, in_flush = 1, flush_cnt decrements each cycle, return to RUN when it reaches 1 -> 0. Redirects are ignored in FLUSH.
- Counters:
  - stall_count += 1 on each cycle with stall = 1.
  - flush_count += 1 on each accepted redirect.
  - Both saturate at 0xFFFFFFFF with no wrap.
- Reset: W and W1 invalid, state RUN, flush_cnt 0, selects 00, stall 0, flush 0, both counters 0. A reset asserted mid-FLUSH or mid-stall returns everything to these values at the next edge, with no residual flush.
- All hazard outputs are combinational from state plus current inputs, with zero-cycle latency. Only the history, FSM and counters are registered.

Test Plan:
- addi x5,x0,7 then add x6,x5,x5 back-to-back -> data_asel = data_bsel = 10 in the add's Execute cycle; stall 0.
- Producer x5, one unrelated instruction, then consumer of x5 -> consumer sees asel = 11; with producers of x5 at both W and W1, asel = 10 (W priority).
- lw x7 then add x8,x7,x0 with LOAD_STALL=1 -> stall = 1 for exactly 1 cycle with asel 00, then asel = 11, stall 0; stall_count = 1. With LOAD_STALL=0 -> asel = 10, no stall.
- Write to x0 followed by a reader of x0, and a producer with regwen=0 -> selects stay 00.
- Taken branch (x_redirect=1, x_valid=1):
  - FLUSH_CYCLES=1 -> flush high for 1 cycle; flush_count = 1.
  - FLUSH_CYCLES=3 -> flush high for 3 cycles; a second redirect during those cycles is ignored; flush_count = 1.
  - x_redirect during stall -> no flush.
- Assert rst during a FLUSH_CYCLES=3 flush -> next cycle flush 0, selects 00, counters 0. Preload stall_count at 0xFFFFFFFF -> a further stall leaves it at 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_fwd_ctrl_if.sv
// Execute-stage hazard bundle between the pipeline datapath and hazard_fwd_ctrl.
// The master is the pipeline; the slave is the hazard controller.
interface hazard_fwd_ctrl_if;
    logic        x_valid;
    logic [4:0]  x_rs1;
    logic [4:0]  x_rs2;
    logic        x_use_rs1;
    logic        x_use_rs2;
    logic [4:0]  x_rd;
    logic        x_regwen;
    logic        x_is_load;
    logic        x_redirect;
    logic [1:0]  data_asel;
    logic [1:0]  data_bsel;
    logic        stall;
    logic        flush;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    modport master (
        output x_valid, x_rs1, x_rs2, x_use_rs1, x_use_rs2,
               x_rd, x_regwen, x_is_load, x_redirect,
        input  data_asel, data_bsel, stall, flush, stall_count, flush_count
    );

    modport slave (
        input  x_valid, x_rs1, x_rs2, x_use_rs1, x_use_rs2,
               x_rd, x_regwen, x_is_load, x_redirect,
        output data_asel, data_bsel, stall, flush, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 3-stage RV32I core: operand forwarding selects,
// load-use stall, redirect flush sequencing and saturating perf counters.
module hazard_fwd_ctrl #(
    parameter bit          LOAD_STALL   = 1'b1,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    hazard_fwd_ctrl_if.slave  hz
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned FC_W  = 2;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_D   = 2'b10;
    localparam logic [1:0] SEL_D1  = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwen;
        logic             is_load;
    } hist_t;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    hist_t            w_q, w1_q, w_d;
    state_t           state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_c, flush_c, redirect_acc, in_flush;
    logic             w_hit1, w_hit2, w1_hit1, w1_hit2;

    function automatic logic hit(input hist_t e, input logic [REG_W-1:0] rs,
                                 input logic use_rs, input logic valid);
        return e.valid && e.regwen && (e.rd != '0) && (e.rd == rs) && use_rs && valid;
    endfunction

    function automatic logic [1:0] pick(input logic hit_w, input logic hit_w1);
        if (hit_w)       return SEL_D;
        else if (hit_w1) return SEL_D1;
        else             return SEL_REG;
    endfunction

    assign in_flush = (state_q == ST_FLUSH);

    assign w_hit1  = hit(w_q,  hz.x_rs1, hz.x_use_rs1, hz.x_valid);
    assign w_hit2  = hit(w_q,  hz.x_rs2, hz.x_use_rs2, hz.x_valid);
    assign w1_hit1 = hit(w1_q, hz.x_rs1, hz.x_use_rs1, hz.x_valid);
    assign w1_hit2 = hit(w1_q, hz.x_rs2, hz.x_use_rs2, hz.x_valid);

    // Load data only reaches the bypass one cycle after MW, so a W-hit on a load waits.
    assign stall_c = LOAD_STALL && hz.x_valid && (w_hit1 || w_hit2) && w_q.is_load;

    always_comb begin
        hz.data_asel = SEL_REG;
        hz.data_bsel = SEL_REG;
        if (!stall_c) begin
            hz.data_asel = pick(w_hit1, w1_hit1);
            hz.data_bsel = pick(w_hit2, w1_hit2);
        end
    end

    // Redirect acceptance and flush sequencing.
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        flush_c      = 1'b0;
        redirect_acc = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.x_redirect && hz.x_valid && !stall_c) begin
                    redirect_acc = 1'b1;
                    flush_c      = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                flush_c = 1'b1;
                fcnt_d  = fcnt_q - FC_W'(1);
                if (fcnt_q == FC_W'(1)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Stalled or flushed slots enter MW as bubbles.
    always_comb begin
        w_d         = '0;
        w_d.valid   = hz.x_valid && !stall_c && !in_flush;
        w_d.rd      = hz.x_rd;
        w_d.regwen  = hz.x_regwen;
        w_d.is_load = hz.x_is_load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q         <= '0;
            w1_q        <= '0;
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            w1_q    <= w_q;
            w_q     <= w_d;
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (stall_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (redirect_acc && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.stall       = stall_c;
    assign hz.flush       = flush_c;
    assign hz.stall_count = stall_cnt_q;
    assign hz.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: instance a (LOAD_STALL=1, FLUSH_CYCLES=1)
// and instance b (LOAD_STALL=0, FLUSH_CYCLES=3) see identical Execute inputs.
module tb_hazard_fwd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl_if ifa ();
    hazard_fwd_ctrl_if ifb ();

    hazard_fwd_ctrl #(.LOAD_STALL(1'b1), .FLUSH_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .hz(ifa));
    hazard_fwd_ctrl #(.LOAD_STALL(1'b0), .FLUSH_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .hz(ifb));

    // Apply one Execute slot to both instances just after the falling edge.
    task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wen, input logic ld, input logic redir);
        @(negedge clk);
        ifa.x_valid = v;  ifa.x_rs1 = rs1; ifa.x_rs2 = rs2; ifa.x_use_rs1 = u1;
        ifa.x_use_rs2 = u2; ifa.x_rd = rd; ifa.x_regwen = wen; ifa.x_is_load = ld;
        ifa.x_redirect = redir;
        ifb.x_valid = v;  ifb.x_rs1 = rs1; ifb.x_rs2 = rs2; ifb.x_use_rs1 = u1;
        ifb.x_use_rs2 = u2; ifb.x_rd = rd; ifb.x_regwen = wen; ifb.x_is_load = ld;
        ifb.x_redirect = redir;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({ifa.data_asel, ifa.data_bsel, ifa.stall, ifa.flush} !== 6'b0) begin
            errors++; $display("FAIL reset_a_outs: got %b exp 000000", {ifa.data_asel, ifa.data_bsel, ifa.stall, ifa.flush});
        end
        checks++;
        if ({ifa.stall_count, ifa.flush_count} !== 64'd0) begin
            errors++; $display("FAIL reset_a_counts: got %h/%h exp 0/0", ifa.stall_count, ifa.flush_count);
        end
        checks++;
        if ({ifb.stall_count, ifb.flush_count, ifb.flush, ifb.stall} !== 66'd0) begin
            errors++; $display("FAIL reset_b: got sc=%h fc=%h fl=%b st=%b exp zeros", ifb.stall_count, ifb.flush_count, ifb.flush, ifb.stall);
        end
    endtask

    task automatic test_fwd_w();
        idle(2);
        drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); // addi x5,x0,7
        checks++;
        if (ifa.data_asel !== 2'b00) begin
            errors++; $display("FAIL fwd_w_x0_src: asel got %b exp 00", ifa.data_asel);
        end
        drv(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); // add x6,x5,x5
        checks++;
        if ({ifa.data_asel, ifa.data_bsel, ifa.stall} !== 5'b10100) begin
            errors++; $display("FAIL fwd_w_a: asel/bsel/stall got %b exp 10100", {ifa.data_asel, ifa.data_bsel, ifa.stall});
        end
        checks++;
        if ({ifb.data_asel, ifb.data_bsel, ifb.stall} !== 5'b10100) begin
            errors++; $display("FAIL fwd_w_b: asel/bsel/stall got %b exp 10100", {ifb.data_asel, ifb.data_bsel, ifb.stall});
        end
    endtask

    task automatic test_fwd_w1();
        idle(2);
        drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({ifa.data_asel, ifa.data_bsel} !== 4'b1100) begin
            errors++; $display("FAIL fwd_w1: asel/bsel got %b exp 1100", {ifa.data_asel, ifa.data_bsel});
        end
        idle(2);
        drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({ifa.data_asel, ifa.data_bsel} !== 4'b0010) begin
            errors++; $display("FAIL fwd_w_priority: asel/bsel got %b exp 0010", {ifa.data_asel, ifa.data_bsel});
        end
    endtask

    task automatic test_load_use();
        idle(2);
        drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); // lw x7
        drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); // add x8,x7,x0
        checks++;
        if ({ifa.stall, ifa.data_asel, ifa.data_bsel} !== 5'b10000) begin
            errors++; $display("FAIL load_use_stall_a: stall/asel/bsel got %b exp 10000", {ifa.stall, ifa.data_asel, ifa.data_bsel});
        end
        checks++;
        if ({ifb.stall, ifb.data_asel} !== 3'b010) begin
            errors++; $display("FAIL load_use_nostall_b: stall/asel got %b exp 010", {ifb.stall, ifb.data_asel});
        end
        drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); // re-presented add
        checks++;
        if ({ifa.stall, ifa.data_asel} !== 3'b011) begin
            errors++; $display("FAIL load_use_replay_a: stall/asel got %b exp 011", {ifa.stall, ifa.data_asel});
        end
        checks++;
        if (ifa.stall_count !== 32'd1) begin
            errors++; $display("FAIL load_use_count_a: got %0d exp 1", ifa.stall_count);
        end
        idle(1);
        checks++;
        if ({ifa.stall_count, ifb.stall_count} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL load_use_count_final: a=%0d b=%0d exp a=1 b=0", ifa.stall_count, ifb.stall_count);
        end
    endtask

    task automatic test_x0_and_nowen();
        idle(2);
        drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); // load into x0
        drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({ifa.data_asel, ifa.data_bsel, ifa.stall} !== 5'b00000) begin
            errors++; $display("FAIL x0_reader: asel/bsel/stall got %b exp 00000", {ifa.data_asel, ifa.data_bsel, ifa.stall});
        end
        idle(2);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0); // store-like, no rd write
        drv(1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({ifa.data_asel, ifa.data_bsel} !== 4'b0000) begin
            errors++; $display("FAIL no_regwen: asel/bsel got %b exp 0000", {ifa.data_asel, ifa.data_bsel});
        end
    endtask

    task automatic test_redirect();
        idle(2);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); // taken branch
        checks++;
        if ({ifa.flush, ifb.flush} !== 2'b11) begin
            errors++; $display("FAIL redirect_first: flush a/b got %b exp 11", {ifa.flush, ifb.flush});
        end
        idle(1);
        checks++;
        if ({ifa.flush, ifb.flush} !== 2'b01) begin
            errors++; $display("FAIL redirect_cycle2: flush a/b got %b exp 01", {ifa.flush, ifb.flush});
        end
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); // second branch
        checks++;
        if ({ifa.flush, ifb.flush} !== 2'b11) begin
            errors++; $display("FAIL redirect_cycle3: flush a/b got %b exp 11", {ifa.flush, ifb.flush});
        end
        idle(1);
        checks++;
        if ({ifa.flush, ifb.flush} !== 2'b00) begin
            errors++; $display("FAIL redirect_done: flush a/b got %b exp 00", {ifa.flush, ifb.flush});
        end
        checks++;
        if ({ifa.flush_count, ifb.flush_count} !== {32'd2, 32'd1}) begin
            errors++; $display("FAIL redirect_counts: a=%0d b=%0d exp a=2 b=1", ifa.flush_count, ifb.flush_count);
        end
    endtask

    task automatic test_redirect_during_stall();
        idle(2);
        drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); // lw x7
        drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); // beq on x7, taken
        checks++;
        if ({ifa.stall, ifa.flush, ifb.flush} !== 3'b101) begin
            errors++; $display("FAIL redirect_stall: a stall/flush, b flush got %b exp 101", {ifa.stall, ifa.flush, ifb.flush});
        end
        idle(3);
        checks++;
        if ({ifa.flush_count, ifb.flush_count} !== {32'd2, 32'd2}) begin
            errors++; $display("FAIL redirect_stall_counts: a=%0d b=%0d exp a=2 b=2", ifa.flush_count, ifb.flush_count);
        end
    endtask

    task automatic test_reset_mid_flush();
        idle(2);
        drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1); // jal x5
        idle(1);
        rst = 1'b1;
        checks++;
        if (ifb.flush !== 1'b1) begin
            errors++; $display("FAIL pre_reset_flush_b: got %b exp 1", ifb.flush);
        end
        drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        checks++;
        if ({ifb.flush, ifa.data_asel, ifb.data_asel} !== 5'b00000) begin
            errors++; $display("FAIL post_reset_outs: b flush/a asel/b asel got %b exp 00000", {ifb.flush, ifa.data_asel, ifb.data_asel});
        end
        checks++;
        if ({ifa.stall_count, ifa.flush_count, ifb.stall_count, ifb.flush_count} !== 128'd0) begin
            errors++; $display("FAIL post_reset_counts: a=%0d/%0d b=%0d/%0d exp all 0", ifa.stall_count, ifa.flush_count, ifb.stall_count, ifb.flush_count);
        end
    endtask

    task automatic test_stall_saturate();
        idle(2);
        drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); // lw x7
        force dut_a.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut_a.stall_cnt_q;
        checks++;
        if (ifa.stall_count !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_preload: got %h exp ffffffff", ifa.stall_count);
        end
        drv(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ifa.stall !== 1'b1) begin
            errors++; $display("FAIL sat_stall: got %b exp 1", ifa.stall);
        end
        idle(1);
        checks++;
        if (ifa.stall_count !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_hold: got %h exp ffffffff", ifa.stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_fwd_w();
        test_fwd_w1();
        test_load_use();
        test_x0_and_nowen();
        test_redirect();
        test_redirect_during_stall();
        test_reset_mid_flush();
        test_stall_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
